// File: rtl/xgemac_tx_pkt_arbiter.sv
// Round-robin, packet-atomic merge of NUM_CH sop/eop streams onto the XGEMAC pkt_tx port.
// Runaway packets are cut at MAX_WORDS; ungranted non-sop words are discarded and flagged.
module xgemac_tx_pkt_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MOD_W      = $clog2(DATA_WIDTH/8),
  parameter int MAX_WORDS  = 190
) (
  input  logic                          clk_156m25,
  input  logic                          reset_156m25,
  input  logic [NUM_CH-1:0]             ch_val,
  input  logic [NUM_CH-1:0]             ch_sop,
  input  logic [NUM_CH-1:0]             ch_eop,
  input  logic [NUM_CH*MOD_W-1:0]       ch_mod,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  ch_data,
  output logic [NUM_CH-1:0]             ch_rdy,
  input  logic                          pkt_tx_full,
  output logic                          pkt_tx_val,
  output logic                          pkt_tx_sop,
  output logic                          pkt_tx_eop,
  output logic [MOD_W-1:0]              pkt_tx_mod,
  output logic [DATA_WIDTH-1:0]         pkt_tx_data,
  output logic [NUM_CH-1:0]             err_stray,
  output logic                          err_trunc,
  output logic [$clog2(NUM_CH)-1:0]     err_ch
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(MAX_WORDS+1);

  typedef enum logic [1:0] {IDLE, PKT, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic [CH_W-1:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;

  logic                  pkt_tx_val_q, pkt_tx_val_d;
  logic                  pkt_tx_sop_q, pkt_tx_sop_d;
  logic                  pkt_tx_eop_q, pkt_tx_eop_d;
  logic [MOD_W-1:0]      pkt_tx_mod_q, pkt_tx_mod_d;
  logic [DATA_WIDTH-1:0] pkt_tx_data_q, pkt_tx_data_d;
  logic [NUM_CH-1:0]     err_stray_q, err_stray_d;
  logic                  err_trunc_q, err_trunc_d;
  logic [CH_W-1:0]       err_ch_q, err_ch_d;

  logic [NUM_CH-1:0]     rdy;
  logic                  found;
  logic [CH_W-1:0]       pick;
  logic [CH_W-1:0]       cand;
  logic                  xfer;
  logic                  last_word;

  logic [DATA_WIDTH-1:0] data_a [NUM_CH];
  logic [MOD_W-1:0]      mod_a  [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign data_a[i] = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign mod_a[i]  = ch_mod[i*MOD_W +: MOD_W];
  end

  // Rotating priority: the channel after the last one served is searched first.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(last_grant_q) + k) % NUM_CH);
      if (!found && ch_val[cand] && ch_sop[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    word_cnt_d    = word_cnt_q;
    rdy           = '0;
    xfer          = 1'b0;
    last_word     = (word_cnt_q == CNT_W'(MAX_WORDS-1));
    pkt_tx_val_d  = 1'b0;
    pkt_tx_sop_d  = 1'b0;
    pkt_tx_eop_d  = 1'b0;
    pkt_tx_mod_d  = '0;
    pkt_tx_data_d = '0;
    err_stray_d   = '0;
    err_trunc_d   = 1'b0;
    err_ch_d      = '0;

    unique case (state_q)
      IDLE: begin
        // Headless words can never start a packet, so they are flushed here.
        rdy         = ch_val & ~ch_sop;
        err_stray_d = ch_val & ~ch_sop;
        if (found) begin
          grant_d    = pick;
          word_cnt_d = '0;
          state_d    = PKT;
        end
      end
      PKT: begin
        rdy[grant_q] = !pkt_tx_full;
        xfer         = ch_val[grant_q] && !pkt_tx_full;
        if (xfer) begin
          pkt_tx_val_d  = 1'b1;
          pkt_tx_sop_d  = (word_cnt_q == '0);
          pkt_tx_data_d = data_a[grant_q];
          if (word_cnt_q != CNT_W'(MAX_WORDS))
            word_cnt_d = word_cnt_q + 1'b1;
          if (ch_eop[grant_q]) begin
            pkt_tx_eop_d = 1'b1;
            pkt_tx_mod_d = mod_a[grant_q];
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else if (last_word) begin
            pkt_tx_eop_d = 1'b1;
            err_trunc_d  = 1'b1;
            err_ch_d     = grant_q;
            state_d      = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Tail of a truncated packet is swallowed without waiting on the MAC.
        rdy[grant_q] = 1'b1;
        if (ch_val[grant_q] && ch_eop[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reset_156m25)
      rdy = '0;
  end

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_grant_q  <= CH_W'(NUM_CH-1);
      word_cnt_q    <= '0;
      pkt_tx_val_q  <= 1'b0;
      pkt_tx_sop_q  <= 1'b0;
      pkt_tx_eop_q  <= 1'b0;
      pkt_tx_mod_q  <= '0;
      pkt_tx_data_q <= '0;
      err_stray_q   <= '0;
      err_trunc_q   <= 1'b0;
      err_ch_q      <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      word_cnt_q    <= word_cnt_d;
      pkt_tx_val_q  <= pkt_tx_val_d;
      pkt_tx_sop_q  <= pkt_tx_sop_d;
      pkt_tx_eop_q  <= pkt_tx_eop_d;
      pkt_tx_mod_q  <= pkt_tx_mod_d;
      pkt_tx_data_q <= pkt_tx_data_d;
      err_stray_q   <= err_stray_d;
      err_trunc_q   <= err_trunc_d;
      err_ch_q      <= err_ch_d;
    end
  end

  assign ch_rdy      = rdy;
  assign pkt_tx_val  = pkt_tx_val_q;
  assign pkt_tx_sop  = pkt_tx_sop_q;
  assign pkt_tx_eop  = pkt_tx_eop_q;
  assign pkt_tx_mod  = pkt_tx_mod_q;
  assign pkt_tx_data = pkt_tx_data_q;
  assign err_stray   = err_stray_q;
  assign err_trunc   = err_trunc_q;
  assign err_ch      = err_ch_q;

endmodule

// File: tb/tb_xgemac_tx_pkt_arbiter.sv
// Bench for xgemac_tx_pkt_arbiter: cycle vector table plus a per-channel packet
// driver feeding an expected-word scoreboard.
module tb_xgemac_tx_pkt_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 64;
  localparam int MW  = 3;

  logic              clk_156m25 = 1'b0;
  logic              reset_156m25;
  logic [NCH-1:0]    ch_val, ch_sop, ch_eop;
  logic [NCH*MW-1:0] ch_mod;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_rdy;
  logic              pkt_tx_full;
  logic              pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
  logic [MW-1:0]     pkt_tx_mod;
  logic [DW-1:0]     pkt_tx_data;
  logic [NCH-1:0]    err_stray;
  logic              err_trunc;
  logic [1:0]        err_ch;

  xgemac_tx_pkt_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW), .MAX_WORDS(8)) dut (
    .clk_156m25(clk_156m25), .reset_156m25(reset_156m25),
    .ch_val(ch_val), .ch_sop(ch_sop), .ch_eop(ch_eop), .ch_mod(ch_mod), .ch_data(ch_data),
    .ch_rdy(ch_rdy), .pkt_tx_full(pkt_tx_full),
    .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop), .pkt_tx_eop(pkt_tx_eop),
    .pkt_tx_mod(pkt_tx_mod), .pkt_tx_data(pkt_tx_data),
    .err_stray(err_stray), .err_trunc(err_trunc), .err_ch(err_ch)
  );

  always #5 clk_156m25 = ~clk_156m25;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [MW-1:0] mod;
    logic [DW-1:0] data;
  } word_t;

  typedef struct packed {
    logic           sop;
    logic           eop;
    logic [MW-1:0]  mod;
    logic [DW-1:0]  data;
    logic           trunc;
    logic [1:0]     ech;
    logic [NCH-1:0] stray;
  } exp_t;

  typedef struct {
    int             ch;
    logic           val, sop, eop;
    logic [MW-1:0]  mod;
    logic [DW-1:0]  data;
    logic [NCH-1:0] x_rdy;
    logic           x_val, x_sop, x_eop;
    logic [MW-1:0]  x_mod;
    logic [DW-1:0]  x_data;
    logic [NCH-1:0] x_stray;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  exp_t  exp_q[$];
  word_t wbuf [NCH][64];
  int    head [NCH];
  int    tail [NCH];
  vec_t  vt [10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int ch, input logic v, input logic s, input logic e,
                              input logic [MW-1:0] m, input logic [DW-1:0] d,
                              input logic [NCH-1:0] xr, input logic xv, input logic xs,
                              input logic xe, input logic [MW-1:0] xm, input logic [DW-1:0] xd,
                              input logic [NCH-1:0] xst);
    vec_t r;
    r.ch = ch; r.val = v; r.sop = s; r.eop = e; r.mod = m; r.data = d;
    r.x_rdy = xr; r.x_val = xv; r.x_sop = xs; r.x_eop = xe; r.x_mod = xm; r.x_data = xd;
    r.x_stray = xst;
    return r;
  endfunction

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NCH; i++) if (head[i] < tail[i]) p = 1'b1;
    return p;
  endfunction

  // Push a packet into a channel buffer and the words it must produce at the MAC.
  task automatic load_pkt(input int ch, input int n, input logic [MW-1:0] m,
                          input logic [DW-1:0] base, input int keep, input bit trunc);
    word_t w;
    exp_t  e;
    for (int k = 0; k < n; k++) begin
      w.sop  = (k == 0);
      w.eop  = (k == n-1);
      w.mod  = (k == n-1) ? m : MW'(k | 1);
      w.data = base + DW'(k);
      wbuf[ch][tail[ch]] = w;
      tail[ch]++;
      if (k < keep) begin
        e.sop   = (k == 0);
        e.eop   = (k == n-1) || (trunc && k == keep-1);
        e.mod   = (k == n-1) ? m : '0;
        e.data  = w.data;
        e.trunc = trunc && (k == keep-1);
        e.ech   = e.trunc ? 2'(ch) : 2'd0;
        e.stray = '0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive();
    word_t w;
    ch_val = '0; ch_sop = '0; ch_eop = '0; ch_mod = '0; ch_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (head[i] < tail[i]) begin
        w = wbuf[i][head[i]];
        ch_val = ch_val | (4'b1 << i);
        if (w.sop) ch_sop = ch_sop | (4'b1 << i);
        if (w.eop) ch_eop = ch_eop | (4'b1 << i);
        ch_mod[i*MW +: MW]  = w.mod;
        ch_data[i*DW +: DW] = w.data;
      end
    end
  endtask

  task automatic monitor();
    exp_t a, e;
    a.sop = pkt_tx_sop; a.eop = pkt_tx_eop; a.mod = pkt_tx_mod; a.data = pkt_tx_data;
    a.trunc = err_trunc; a.ech = err_ch; a.stray = err_stray;
    if (pkt_tx_val) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h required=none", a);
      end else begin
        e = exp_q.pop_front();
        chk("tx_word", 128'(a), 128'(e));
      end
    end else begin
      chk("tx_idle", 128'({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, err_trunc, err_stray}), 128'(0));
    end
  endtask

  task automatic cyc();
    logic [NCH-1:0] acc;
    @(negedge clk_156m25);
    monitor();
    acc = ch_val & ch_rdy;
    @(posedge clk_156m25);
    #1;
    for (int i = 0; i < NCH; i++) if (((acc >> i) & 4'd1) != 4'd0) head[i]++;
    drive();
  endtask

  task automatic drain_all(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || pending()) && n < budget) begin
      cyc();
      n++;
    end
    chk({name, "_expected_left"}, 128'(exp_q.size()), 128'(0));
    chk({name, "_input_left"}, 128'(pending()), 128'(0));
    cyc();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NCH; i++) begin head[i] = 0; tail[i] = 0; end
    reset_156m25 = 1'b1;
    pkt_tx_full  = 1'b0;
    ch_val = '0; ch_sop = '0; ch_eop = '0; ch_mod = '0; ch_data = '0;

    // Reset held for 3 edges, then 10 quiet cycles: everything stays at zero.
    repeat (3) begin
      @(posedge clk_156m25);
      @(negedge clk_156m25);
      chk("reset_outputs", 128'({ch_rdy, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod,
          pkt_tx_data, err_stray, err_trunc, err_ch}), 128'(0));
    end
    @(posedge clk_156m25);
    #1 reset_156m25 = 1'b0;
    repeat (10) begin
      @(negedge clk_156m25);
      chk("idle_outputs", 128'({ch_rdy, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod,
          pkt_tx_data, err_stray, err_trunc, err_ch}), 128'(0));
      @(posedge clk_156m25);
      #1;
    end

    // Single 4-word packet on channel 2 (one bubble, 1-cycle latency), then a stray on channel 3.
    vt[0] = mk(2, 1, 1, 0, 0, 64'hA0, 4'b0000, 0, 0, 0, 0, 64'h0,  4'b0000);
    vt[1] = mk(2, 1, 1, 0, 0, 64'hA0, 4'b0100, 0, 0, 0, 0, 64'h0,  4'b0000);
    vt[2] = mk(2, 1, 0, 0, 7, 64'hA1, 4'b0100, 1, 1, 0, 0, 64'hA0, 4'b0000);
    vt[3] = mk(2, 1, 0, 0, 6, 64'hA2, 4'b0100, 1, 0, 0, 0, 64'hA1, 4'b0000);
    vt[4] = mk(2, 1, 0, 1, 5, 64'hA3, 4'b0100, 1, 0, 0, 0, 64'hA2, 4'b0000);
    vt[5] = mk(2, 0, 0, 0, 0, 64'h0,  4'b0000, 1, 0, 1, 5, 64'hA3, 4'b0000);
    vt[6] = mk(2, 0, 0, 0, 0, 64'h0,  4'b0000, 0, 0, 0, 0, 64'h0,  4'b0000);
    vt[7] = mk(3, 1, 0, 0, 2, 64'h55, 4'b1000, 0, 0, 0, 0, 64'h0,  4'b0000);
    vt[8] = mk(3, 0, 0, 0, 0, 64'h0,  4'b0000, 0, 0, 0, 0, 64'h0,  4'b1000);
    vt[9] = mk(3, 0, 0, 0, 0, 64'h0,  4'b0000, 0, 0, 0, 0, 64'h0,  4'b0000);
    for (int r = 0; r < 10; r++) begin
      ch_val = '0; ch_sop = '0; ch_eop = '0; ch_mod = '0; ch_data = '0;
      ch_val = 4'(vt[r].val) << vt[r].ch;
      ch_sop = 4'(vt[r].sop) << vt[r].ch;
      ch_eop = 4'(vt[r].eop) << vt[r].ch;
      ch_mod[vt[r].ch*MW +: MW]  = vt[r].mod;
      ch_data[vt[r].ch*DW +: DW] = vt[r].data;
      @(negedge clk_156m25);
      chk($sformatf("vec%0d_rdy", r), 128'(ch_rdy), 128'(vt[r].x_rdy));
      chk($sformatf("vec%0d_out", r),
          128'({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data, err_stray}),
          128'({vt[r].x_val, vt[r].x_sop, vt[r].x_eop, vt[r].x_mod, vt[r].x_data, vt[r].x_stray}));
      @(posedge clk_156m25);
      #1;
    end

    // Backpressure: 5 full cycles in the middle of a channel 1 packet.
    load_pkt(1, 6, 3'd2, 64'hB100, 6, 1'b0);
    drive();
    repeat (3) cyc();
    pkt_tx_full = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("bp_rdy1", 128'((ch_rdy >> 1) & 4'd1), 128'(0));
      if (j > 0) chk("bp_val", 128'(pkt_tx_val), 128'(0));
      cyc();
    end
    pkt_tx_full = 1'b0;
    #1 chk("bp_val_last", 128'(pkt_tx_val), 128'(0));
    drain_all("bp", 40);

    // Watchdog: 12-word packet cut at 8, tail drained, then a normal packet proves return to IDLE.
    load_pkt(0, 12, 3'd3, 64'hC000, 8, 1'b1);
    load_pkt(0, 2, 3'd4, 64'hC100, 2, 1'b0);
    drive();
    drain_all("wdog", 60);

    // Reset on word 3 of a 6-word packet; afterwards channel 0 must win over channel 3.
    load_pkt(2, 6, 3'd1, 64'hD200, 2, 1'b0);
    drive();
    repeat (3) cyc();
    reset_156m25 = 1'b1;
    #1 chk("midrst_rdy", 128'(ch_rdy), 128'(0));
    head[2] = tail[2];
    load_pkt(0, 2, 3'd6, 64'hD000, 2, 1'b0);
    load_pkt(3, 2, 3'd7, 64'hD300, 2, 1'b0);
    cyc();
    reset_156m25 = 1'b0;
    #1 chk("midrst_out", 128'({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data,
                               err_trunc, err_stray}), 128'(0));
    drain_all("midrst", 40);

    // Round robin across channels 0, 1, 3 with two back-to-back packets each.
    for (int p = 0; p < 2; p++) begin
      load_pkt(0, 2, 3'd1, 64'hE000 + 64'(p*16), 2, 1'b0);
      load_pkt(1, 2, 3'd2, 64'hE100 + 64'(p*16), 2, 1'b0);
      load_pkt(3, 2, 3'd3, 64'hE300 + 64'(p*16), 2, 1'b0);
    end
    drive();
    drain_all("rr", 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xgemac_tx_pkt_arbiter.md
Name: xgemac_tx_pkt_arbiter

Overview:
Parametrised N-channel packet arbiter feeding the XGEMAC packet-transmit interface (pkt_tx_*) on the 156.25 MHz core clock. It merges NUM_CH independent sop/eop-framed streams onto one MAC port. Grants are round-robin and packet-atomic: a grant is held from sop to eop. The block honours pkt_tx_full backpressure, truncates runaway packets with a length watchdog, and flags framing errors per channel.

Parameters:
NUM_CH, 4, number of input channels (2..16)
DATA_WIDTH, 64, data word width in bits (multiple of 8, power of two)
MOD_W, $clog2(DATA_WIDTH/8), width of the valid-byte field (derived; do not override)
MAX_WORDS, 190, maximum words per packet before forced truncation (>=2)

Ports:
clk_156m25  in  1  core clock
reset_156m25  in  1  synchronous active-high reset
ch_val  in  NUM_CH  per-channel word valid
ch_sop  in  NUM_CH  per-channel start of packet
ch_eop  in  NUM_CH  per-channel end of packet
ch_mod  in  NUM_CH*MOD_W  per-channel valid bytes in eop word (0 = all valid)
ch_data  in  NUM_CH*DATA_WIDTH  per-channel data; channel i occupies slice i
ch_rdy  out  NUM_CH  per-channel accept
pkt_tx_full  in  1  MAC backpressure
pkt_tx_val  out  1  output word valid
pkt_tx_sop  out  1  output start of packet
pkt_tx_eop  out  1  output end of packet
pkt_tx_mod  out  MOD_W  output valid bytes
pkt_tx_data  out  DATA_WIDTH  output data
err_stray  out  NUM_CH  one-cycle pulse: non-sop word discarded while channel ungranted
err_trunc  out  1  one-cycle pulse, coincident with a forced eop
err_ch  out  $clog2(NUM_CH)  channel index for err_trunc

Behaviour:
- Single clock domain. Reset is synchronous and active-high: all outputs, state and counters clear on any clock edge where reset_156m25=1. This includes reset mid-packet; no eop is emitted for the aborted packet. Reset values: all pkt_tx_* = 0, ch_rdy = 0, err_* = 0. last_grant resets to NUM_CH-1, so channel 0 has first priority.
- A word transfers on channel i when ch_val[i] && ch_rdy[i].
- ch_rdy is combinational from state, grant and pkt_tx_full.
- Each transferred granted word appears on pkt_tx_* exactly 1 cycle later, from registered outputs. pkt_tx_val=0 in every cycle that has no transfer.
- FSM states: IDLE, PKT, DRAIN.
- IDLE:
  - Search channels last_grant+1 .. last_grant+NUM_CH (mod NUM_CH) for the first with ch_val && ch_sop.
  - If one is found, register grant=g, clear word_cnt, go to PKT. No word is accepted in this cycle, which gives one bubble per packet.
  - Every channel with ch_val=1 && ch_sop=0 gets ch_rdy=1. Its word is discarded and err_stray[i] pulses.
- PKT:
  - ch_rdy[grant] = !pkt_tx_full. All other ch_rdy = 0.
  - On each transfer, word_cnt increments.
  - The output sop bit equals (word_cnt==0). ch_sop on later words is ignored.
  - Transfer with ch_eop=1: output eop=1 and mod=ch_mod[grant]. Then last_grant=grant and go to IDLE.
  - Transfer of word number MAX_WORDS (word_cnt==MAX_WORDS-1) with ch_eop=0: output eop=1, mod=0, err_trunc=1, err_ch=grant. Go to DRAIN.
  - Transfer of word MAX_WORDS with ch_eop=1 is a normal eop with no error.
- DRAIN:
  - ch_rdy[grant]=1 regardless of pkt_tx_full. Words are discarded and nothing is output.
  - On the discarded eop word, set last_grant=grant and go to IDLE.
- pkt_tx_full changes take effect in the same cycle through ch_rdy. The MAC's full slack covers the 1-cycle output register.
- The ch_mod value on non-eop words is ignored, and output mod=0 on them.
- word_cnt width is $clog2(MAX_WORDS+1). It saturates and never wraps.

Test Plan:
- Reset then idle: hold reset 3 cycles, then drive no traffic for 10 cycles -> all outputs 0 throughout; ch_rdy=0.
- Single packet: channel 2 sends 4 words A0..A3, eop mod=5 -> pkt_tx emits A0..A3 one cycle after each accept; sop on A0; eop with mod=5 on A3; 1 bubble before A0.
- Round-robin fairness: channels 0, 1 and 3 each continuously offer 2-word packets -> output channel order is 0,1,3,0,1,3. No packet is interleaved.
- Backpressure: pkt_tx_full=1 for 5 cycles mid-packet on channel 1 -> ch_rdy[1]=0 and pkt_tx_val=0 for those cycles. Data order is intact with no duplicates or loss.
- Watchdog (MAX_WORDS=8): channel 0 sends 12 words with eop on word 12 -> 8 words are output, the 8th with eop=1, mod=0, err_trunc=1, err_ch=0. Words 9..12 are dropped, then the arbiter returns to IDLE.
- Stray and mid-reset: channel 3 presents a non-sop word while IDLE -> ch_rdy[3]=1 and err_stray[3] pulses. Then assert reset on word 3 of a 6-word packet -> outputs are 0 next cycle, no eop is emitted, and the next packet starts cleanly from channel 0 priority.
